cache_page_scheduler: RTL and testbench

//  Sequences page loads/flushes for the external-memory cache. Collects per-page load/flush

---
 rtl/cache_page_scheduler.sv | 153 +++++++++++++++
 tb/tb_cache_page_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_page_scheduler.sv
// Round-robin page load/flush scheduler for the external-memory cache.
// Picks one pending page, hands a single transfer to the flash engine and acknowledges the page on completion.
module cache_page_scheduler #(
    parameter int PAGE_INDEX_ADDRESS_SIZE = 3,
    parameter int PAGE_NUMBER_SIZE        = 13,
    parameter int TIMEOUT_CYCLES          = 4096,
    localparam int PAGE_COUNT             = 1 << PAGE_INDEX_ADDRESS_SIZE
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic [PAGE_COUNT-1:0]                  pageRequestLoad,
    input  logic [PAGE_COUNT-1:0]                  pageRequestFlush,
    input  logic [PAGE_COUNT*PAGE_NUMBER_SIZE-1:0] pageLoadNumber,
    input  logic [PAGE_COUNT*PAGE_NUMBER_SIZE-1:0] pageFlushNumber,
    output logic [PAGE_COUNT-1:0]                  pageLoadDone,
    output logic [PAGE_COUNT-1:0]                  pageFlushDone,
    output logic                                   transfer_start,
    input  logic                                   transfer_ready,
    output logic                                   transfer_write,
    output logic [PAGE_INDEX_ADDRESS_SIZE-1:0]     transfer_pageIndex,
    output logic [PAGE_NUMBER_SIZE-1:0]            transfer_pageNumber,
    input  logic                                   transfer_done,
    output logic                                   cacheBusy,
    output logic                                   cacheRequestData,
    output logic                                   cacheStoreData,
    output logic                                   transferTimeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t                               r_state;
    state_t                               w_next_state;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0]   r_rr_ptr;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0]   r_index;
    logic                                 r_write;
    logic [PAGE_NUMBER_SIZE-1:0]          r_number;
    logic [WD_W-1:0]                      r_wd_count;
    logic                                 r_req_data;
    logic                                 r_store_data;

    logic [PAGE_COUNT-1:0]                w_pending;
    logic                                 w_sel_found;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0]   w_sel_index;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0]   w_cand;
    logic                                 w_sel_write;
    logic [PAGE_NUMBER_SIZE-1:0]          w_sel_number;
    logic                                 w_accept;
    logic                                 w_timeout;
    logic                                 w_active_write;

    assign w_pending = pageRequestLoad | pageRequestFlush;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_index = '0;
        w_cand      = '0;
        // Search starts just after the last accepted page; the index width wraps modulo PAGE_COUNT.
        for (int k = 1; k <= PAGE_COUNT; k++) begin
            w_cand = r_rr_ptr + PAGE_INDEX_ADDRESS_SIZE'(k);
            if (!w_sel_found && w_pending[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_index = w_cand;
            end
        end
    end

    assign w_sel_write  = pageRequestFlush[w_sel_index];
    assign w_sel_number = w_sel_write
                        ? pageFlushNumber[int'(w_sel_index) * PAGE_NUMBER_SIZE +: PAGE_NUMBER_SIZE]
                        : pageLoadNumber[int'(w_sel_index) * PAGE_NUMBER_SIZE +: PAGE_NUMBER_SIZE];

    assign w_accept  = (r_state == S_ISSUE) && transfer_ready;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) && !transfer_done
                       && (r_wd_count == WD_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && w_sel_found)
                    w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                // An accept already seen by the engine cannot be withdrawn.
                if (transfer_ready)
                    w_next_state = S_WAIT;
                else if (!enable)
                    w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (transfer_done)
                    w_next_state = S_COMPLETE;
                else if (w_timeout)
                    w_next_state = S_IDLE;
            end
            S_COMPLETE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    assign w_active_write = (r_state == S_IDLE) ? w_sel_write : r_write;

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '1;
            r_index      <= '0;
            r_write      <= 1'b0;
            r_number     <= '0;
            r_wd_count   <= '0;
            r_req_data   <= 1'b0;
            r_store_data <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_next_state == S_ISSUE) begin
                r_index  <= w_sel_index;
                r_write  <= w_sel_write;
                r_number <= w_sel_number;
            end
            if (w_accept) begin
                r_rr_ptr   <= r_index;
                r_wd_count <= '0;
            end else if (r_state == S_WAIT && r_wd_count != WD_LAST) begin
                r_wd_count <= r_wd_count + 1'b1;
            end
            r_req_data   <= (w_next_state != S_IDLE) && !w_active_write;
            r_store_data <= (w_next_state != S_IDLE) &&  w_active_write;
        end
    end

    assign transfer_start      = (r_state == S_ISSUE);
    assign transfer_write      = r_write;
    assign transfer_pageIndex  = r_index;
    assign transfer_pageNumber = r_number;
    assign cacheBusy           = (r_state != S_IDLE);
    assign cacheRequestData    = r_req_data;
    assign cacheStoreData      = r_store_data;
    assign transferTimeout     = w_timeout;
    assign pageLoadDone  = (r_state == S_COMPLETE && !r_write) ? (PAGE_COUNT'(1) << r_index) : '0;
    assign pageFlushDone = (r_state == S_COMPLETE &&  r_write) ? (PAGE_COUNT'(1) << r_index) : '0;

endmodule

// File: tb/tb_cache_page_scheduler.sv
// Self-checking bench for cache_page_scheduler: directed scenarios followed by randomized
// transactions checked against a round-robin reference model of the page requesters.
module tb_cache_page_scheduler;

    localparam int PI  = 3;
    localparam int PC  = 8;
    localparam int PNS = 13;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [PC-1:0]     pageRequestLoad, pageRequestFlush;
    logic [PC*PNS-1:0] pageLoadNumber, pageFlushNumber;
    logic [PC-1:0]     pageLoadDone, pageFlushDone;
    logic              transfer_start, transfer_ready, transfer_write, transfer_done;
    logic [PI-1:0]     transfer_pageIndex;
    logic [PNS-1:0]    transfer_pageNumber;
    logic              cacheBusy, cacheRequestData, cacheStoreData, transferTimeout;

    int errors = 0;
    int checks = 0;

    // Reference model: requester state and the last page the engine accepted.
    logic [PC-1:0]  m_load, m_flush;
    logic [PNS-1:0] m_ld_num [PC];
    logic [PNS-1:0] m_fl_num [PC];
    int             m_rr;

    cache_page_scheduler #(
        .PAGE_INDEX_ADDRESS_SIZE(PI),
        .PAGE_NUMBER_SIZE(PNS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pageRequestLoad(pageRequestLoad),
        .pageRequestFlush(pageRequestFlush),
        .pageLoadNumber(pageLoadNumber),
        .pageFlushNumber(pageFlushNumber),
        .pageLoadDone(pageLoadDone),
        .pageFlushDone(pageFlushDone),
        .transfer_start(transfer_start),
        .transfer_ready(transfer_ready),
        .transfer_write(transfer_write),
        .transfer_pageIndex(transfer_pageIndex),
        .transfer_pageNumber(transfer_pageNumber),
        .transfer_done(transfer_done),
        .cacheBusy(cacheBusy),
        .cacheRequestData(cacheRequestData),
        .cacheStoreData(cacheStoreData),
        .transferTimeout(transferTimeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        pageRequestLoad  = m_load;
        pageRequestFlush = m_flush;
        for (int i = 0; i < PC; i++) begin
            pageLoadNumber[i*PNS +: PNS]  = m_ld_num[i];
            pageFlushNumber[i*PNS +: PNS] = m_fl_num[i];
        end
    endtask

    // First requesting page strictly after the last served one, wrapping around the page ring.
    function automatic int pick(input logic [PC-1:0] pend, input int rr);
        for (int k = 1; k <= PC; k++) begin
            if (pend[(rr + k) % PC])
                return (rr + k) % PC;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  cacheBusy, 0);
        check({tag, "_start"}, transfer_start, 0);
        check({tag, "_ldone"}, pageLoadDone, 0);
        check({tag, "_fdone"}, pageFlushDone, 0);
        check({tag, "_rdata"}, cacheRequestData, 0);
        check({tag, "_sdata"}, cacheStoreData, 0);
    endtask

    // Called at the negedge of an IDLE cycle with requests already driven; returns in the next IDLE cycle.
    task automatic do_xfer(input int ready_delay, input int done_delay, input bit clear_req, input bit drop_enable);
        int             idx;
        bit             wr;
        logic [PNS-1:0] num;
        idx = pick(m_load | m_flush, m_rr);
        wr  = m_flush[idx];
        num = wr ? m_fl_num[idx] : m_ld_num[idx];
        transfer_ready = 1'b0;
        step();
        check("issue_start",  transfer_start, 1);
        check("issue_write",  transfer_write, 32'(wr));
        check("issue_index",  transfer_pageIndex, idx);
        check("issue_number", transfer_pageNumber, num);
        check("issue_sdata",  cacheStoreData, 32'(wr));
        check("issue_rdata",  cacheRequestData, 32'(!wr));
        repeat (ready_delay) begin
            step();
            check("hold_start", transfer_start, 1);
            check("hold_index", transfer_pageIndex, idx);
        end
        transfer_ready = 1'b1;
        step();
        transfer_ready = 1'b0;
        m_rr = idx;
        check("wait_start", transfer_start, 0);
        check("wait_busy",  cacheBusy, 1);
        if (drop_enable)
            enable = 1'b0;
        repeat (done_delay) step();
        transfer_done = 1'b1;
        step();
        transfer_done = 1'b0;
        check("cmpl_ldone", pageLoadDone,  wr ? 0 : (1 << idx));
        check("cmpl_fdone", pageFlushDone, wr ? (1 << idx) : 0);
        check("cmpl_sdata", cacheStoreData, 32'(wr));
        if (clear_req) begin
            if (wr) m_flush[idx] = 1'b0;
            else    m_load[idx]  = 1'b0;
            drive_reqs();
        end
        enable = 1'b1;
        step();
        check_idle_outputs("post");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; transfer_ready = 1'b0; transfer_done = 1'b0;
        m_load = '0; m_flush = '0; m_rr = PC - 1;
        for (int i = 0; i < PC; i++) begin
            m_ld_num[i] = '0;
            m_fl_num[i] = '0;
        end
        drive_reqs();
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_timeout", transferTimeout, 0);
        check("reset_write",   transfer_write, 0);
        check("reset_index",   transfer_pageIndex, 0);
        check("reset_number",  transfer_pageNumber, 0);
        rst = 1'b0;
        step();

        // Single load of page 2 with minimum latency.
        m_ld_num[2] = 13'h0123; m_load = 8'h04; enable = 1'b1; transfer_ready = 1'b1;
        drive_reqs();
        step();
        check("t1_start",  transfer_start, 1);
        check("t1_write",  transfer_write, 0);
        check("t1_index",  transfer_pageIndex, 2);
        check("t1_number", transfer_pageNumber, 32'h123);
        step();
        transfer_ready = 1'b0;
        transfer_done  = 1'b1;
        step();
        transfer_done = 1'b0;
        check("t1_ldone", pageLoadDone, 32'h04);
        m_load = '0; drive_reqs();
        step();
        check("t1_ldone_clr", pageLoadDone, 0);

        // Wrap-around order from a fresh reset with pages 0 and 7 held.
        rst = 1'b1; step(); rst = 1'b0; m_rr = PC - 1;
        m_ld_num[0] = 13'h0AAA; m_ld_num[7] = 13'h1777; m_load = 8'h81; drive_reqs();
        step();
        do_xfer(0, 0, 0, 0);
        do_xfer(1, 2, 0, 0);
        do_xfer(0, 1, 0, 0);
        m_load = '0; drive_reqs();
        step();
        check_idle_outputs("t2_drain");

        // Flush has priority over a load of the same page.
        m_fl_num[3] = 13'h0F33; m_ld_num[3] = 13'h0333; m_load[3] = 1'b1; m_flush[3] = 1'b1;
        drive_reqs();
        do_xfer(1, 2, 1, 0);
        do_xfer(0, 1, 1, 0);

        // Withdrawal while ready is low, then enable drop after accept.
        m_ld_num[5] = 13'h0555; m_load[5] = 1'b1; drive_reqs();
        transfer_ready = 1'b0;
        step();
        check("t4_start", transfer_start, 1);
        check("t4_index", transfer_pageIndex, 5);
        repeat (10) begin
            step();
            check("t4_hold", transfer_start, 1);
        end
        enable = 1'b0;
        step();
        check_idle_outputs("t4_withdraw");
        repeat (3) begin
            step();
            check("t4_dis_start", transfer_start, 0);
            check("t4_dis_busy",  cacheBusy, 0);
        end
        enable = 1'b1;
        do_xfer(0, 3, 1, 1);

        // Watchdog expiry 16 cycles after accept, then the other pending page is served.
        m_ld_num[1] = 13'h0111; m_ld_num[6] = 13'h0666; m_load[1] = 1'b1; m_load[6] = 1'b1;
        drive_reqs();
        transfer_ready = 1'b1;
        step();
        check("t5_index", transfer_pageIndex, 6);
        step();
        transfer_ready = 1'b0;
        m_rr = 6;
        for (int j = 1; j < TO; j++) begin
            check("t5_no_timeout", transferTimeout, 0);
            check("t5_busy",       cacheBusy, 1);
            check("t5_no_ldone",   pageLoadDone, 0);
            step();
        end
        check("t5_timeout", transferTimeout, 1);
        step();
        check("t5_timeout_clr", transferTimeout, 0);
        check_idle_outputs("t5_after");
        do_xfer(0, 2, 1, 0);

        // Reset during WAIT aborts; a late done is ignored.
        transfer_ready = 1'b1;
        step();
        check("t6_index", transfer_pageIndex, 6);
        step();
        transfer_ready = 1'b0;
        step();
        rst = 1'b1;
        m_load = '0; m_flush = '0; drive_reqs();
        step();
        check_idle_outputs("t6_rst");
        check("t6_write",  transfer_write, 0);
        check("t6_index0", transfer_pageIndex, 0);
        rst = 1'b0; m_rr = PC - 1;
        transfer_done = 1'b1;
        step();
        transfer_done = 1'b0;
        check_idle_outputs("t6_late_done");
        step();
        check_idle_outputs("t6_quiet");

        // Round-robin pointer restarts from the top after reset.
        m_load = 8'h81; drive_reqs();
        do_xfer(0, 0, 1, 0);
        do_xfer(0, 0, 1, 0);

        // Randomized transactions against the requester model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < PC; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    m_load[i]   = 1'b1;
                    m_ld_num[i] = PNS'($urandom);
                end
                if ($urandom_range(0, 4) == 0) begin
                    m_flush[i]  = 1'b1;
                    m_fl_num[i] = PNS'($urandom);
                end
            end
            if ((m_load | m_flush) == '0)
                m_load[$urandom_range(0, PC - 1)] = 1'b1;
            drive_reqs();
            if ($urandom_range(0, 4) == 0) begin
                enable = 1'b0;
                repeat (2) begin
                    step();
                    check("rnd_dis_start", transfer_start, 0);
                    check("rnd_dis_busy",  cacheBusy, 0);
                end
                enable = 1'b1;
            end
            do_xfer($urandom_range(0, 3), $urandom_range(0, 6), 1, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
